gray_code_counter: RTL
======================

// Module: gray_code_counter
// PURPOSE
//   Synchronous up/down counter that produces a registered Gray-code count and
//   its binary equivalent. It is the producer stage that feeds gray_binary_converter
//   and the pointer-generation blocks; successive gray_out values differ in exactly one bit.
//   Supports clear, load of a Gray-coded value, and a one-cycle wrap indication.
// PARAMETERS
//   WIDTH      4    count width in bits (>=2); period is 2**WIDTH
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      count enable (one step per cycle while high)
//   up_dn      in   1      1 = count up, 0 = count down; sampled only when en=1
//   clr        in   1      synchronous clear to zero
//   load       in   1      synchronous load from load_gray
//   load_gray  in   WIDTH  Gray-coded value to load
//   gray_out   out  WIDTH  registered Gray count
//   bin_out    out  WIDTH  registered binary count (gray_out == bin_out ^ (bin_out>>1))
//   wrap       out  1      registered 1-cycle pulse on modular wrap
// BEHAVIOUR
//   - Reset (rst_n=0, any time, including mid-count): gray_out=0, bin_out=0, wrap=0
//     immediately; first step after release is at the first clk edge with rst_n=1.
//   - Internal state: binary register bin_q; gray_q registered alongside it from the
//     next-state binary value (no combinational path from bin_q to gray_out).
//     Both outputs change on the same edge; latency from control input to output = 1 clk.
//   - Per-edge priority: clr > load > en > hold.
//     clr: bin_q<=0, gray_q<=0, wrap<=0.
//     load: bin_q<=gray2bin(load_gray), gray_q<=load_gray, wrap<=0.
//     en&up_dn: bin_q<=bin_q+1 mod 2**WIDTH; wrap<=1 iff bin_q was all-ones.
//     en&!up_dn: bin_q<=bin_q-1 mod 2**WIDTH; wrap<=1 iff bin_q was zero.
//     otherwise hold; wrap<=0.
//   - wrap is high for exactly one cycle per wrap; continuous counting through
//     the boundary re-asserts it once per period.
//   - Direction change between consecutive enabled cycles is legal; gray_out
//     still changes exactly one bit per step.
//   - Arithmetic is unsigned WIDTH-bit, overflow discarded; no sign extension.
//   - Inputs are assumed synchronous to clk; no internal synchronisers.
// STRUCTURE
//   - Package gray_pkg: functions bin2gray(b) = b ^ (b >> 1) and gray2bin(g)
//     (MSB-down XOR prefix), parameterised by WIDTH through an unsized loop.
//     gray_binary_converter reuses the same gray2bin function.
//   - One natural sub-module: gray_step_next (combinational next-state: bin_q,
//     ctrl -> next bin, next gray, wrap_next); this top holds only the registers.
//   - Simulation-only assertion: when en && !clr && !load, $countones of
//     gray_q ^ gray_q_prev equals 1 on the following cycle.
// TESTING (WIDTH=4)
//   1. rst_n=0 then release, en=0 for 3 clks -> gray_out=0000, bin_out=0000, wrap=0 throughout.
//   2. en=1, up_dn=1 for 16 clks from 0 -> gray_out 0000,0001,0011,0010,0110,0111,0101,
//      0100,1100,...,1000,0000; wrap=1 only in the cycle gray_out returns to 0000.
//   3. From 0, en=1, up_dn=0 for 1 clk -> gray_out=1000, bin_out=1111, wrap=1;
//      next clk -> gray_out=1001, bin_out=1110, wrap=0.
//   4. load=1, load_gray=1101 -> bin_out=1001 next clk; then 1 up step -> gray_out=1111, bin_out=1010.
//   5. clr=1, load=1, en=1 together on bin_out=0101 -> bin_out=0000, gray_out=0000, wrap=0.
//   6. Count up to bin_out=0110, assert rst_n=0 between edges -> outputs 0000 without a clk edge;
//      release -> counting resumes 0001,0011 from zero. Single-bit-change assertion never fires.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: binary/Gray conversion helpers shared by the counter and converter blocks
package gray_pkg;
  localparam int MAX_W = 32;
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Zero-extended inputs keep the MSB-down prefix XOR correct for any width up to MAX_W
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_step_next.sv
// gray_step_next: combinational next binary/Gray state and wrap for the Gray counter
module gray_step_next
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_q,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap_next
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] loaded_bin;
  logic [WIDTH-1:0] stepped;
  always_comb begin
    loaded_bin = WIDTH'(gray2bin(MAX_W'(load_gray)));
    stepped    = up_dn ? bin_q + ONE : bin_q - ONE;
    bin_next   = clr ? '0 : load ? loaded_bin : en ? stepped : bin_q;
    gray_next  = WIDTH'(bin2gray(MAX_W'(bin_next)));
    wrap_next  = !clr && !load && en && (up_dn ? &bin_q : ~|bin_q);
  end
endmodule

// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down counter with registered Gray and binary outputs plus wrap pulse
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);
  logic [WIDTH-1:0] bin_q, gray_q, bin_next, gray_next;
  logic             wrap_q, wrap_next;
  gray_step_next #(.WIDTH(WIDTH)) u_step (
    .bin_q     (bin_q),
    .en        (en),
    .up_dn     (up_dn),
    .clr       (clr),
    .load      (load),
    .load_gray (load_gray),
    .bin_next  (bin_next),
    .gray_next (gray_next),
    .wrap_next (wrap_next)
  );
  // Gray is registered from the next binary value so gray_out has no decode logic after the flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end
  assign gray_out = gray_q;
  assign bin_out  = bin_q;
  assign wrap     = wrap_q;
  a_one_bit_step: assert property (@(posedge clk) disable iff (!rst_n)
    (en && !clr && !load) |=> $countones(gray_q ^ $past(gray_q)) == 1);
endmodule
